// File: rtl/gcd_binary_queue.sv
// gcd_binary_queue: binary (Stein) GCD engine with job tags and a show-ahead
// result FIFO so the engine can take new work while earlier results wait.
// Optional build macro GCD_STATS_EN adds a per-result cycle count output.
module gcd_binary_queue #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int DEPTH = 4,
   parameter int CYC_W = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       input_ready,
   input  logic                       input_valid,
   input  logic [WIDTH-1:0]           x,
   input  logic [WIDTH-1:0]           y,
   input  logic [TAG_W-1:0]           in_tag,
   input  logic                       output_ready,
   output logic                       output_valid,
   output logic [WIDTH-1:0]           gcd,
   output logic [TAG_W-1:0]           out_tag,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     count
`ifdef GCD_STATS_EN
   ,
   output logic [CYC_W-1:0]           cycles
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int K_W   = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STRIP,
      S_ODDA,
      S_RUN,
      S_PUSH
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [K_W-1:0]     k_q;
   logic [TAG_W-1:0]   tag_q;
   logic [WIDTH-1:0]   res_q;

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [WIDTH-1:0]   mem_gcd_q [DEPTH];
   logic [TAG_W-1:0]   mem_tag_q [DEPTH];

   logic               accept;
   logic               fifo_full;
   logic               push;
   logic               pop;

   // The full test uses the pre-pop count, so a pop never frees a slot for
   // a push in the same cycle.
   assign fifo_full    = (count_q == DEPTH_C);
   assign accept       = input_valid && (state_q == S_IDLE);
   assign push         = (state_q == S_PUSH) && !fifo_full;
   assign output_valid = (count_q != '0);
   assign pop          = output_valid && output_ready;

   assign input_ready  = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign count        = count_q;

   // Head entry is gated by valid so the outputs read 0 whenever the FIFO is empty.
   assign gcd          = output_valid ? mem_gcd_q[rd_ptr_q] : '0;
   assign out_tag      = output_valid ? mem_tag_q[rd_ptr_q] : '0;

   // Engine FSM: one Stein step per cycle, result held in PUSH until a slot is free.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         tag_q   <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (input_valid) begin
                  a_q     <= x;
                  b_q     <= y;
                  k_q     <= '0;
                  tag_q   <= in_tag;
                  state_q <= S_STRIP;
               end
            end
            S_STRIP: begin
               if ((a_q == '0) || (b_q == '0)) begin
                  res_q   <= (a_q | b_q) << k_q;
                  state_q <= S_PUSH;
               end else if (!a_q[0] && !b_q[0]) begin
                  a_q <= a_q >> 1;
                  b_q <= b_q >> 1;
                  k_q <= k_q + 1'b1;
               end else begin
                  state_q <= S_ODDA;
               end
            end
            S_ODDA: begin
               if (!a_q[0]) begin
                  a_q <= a_q >> 1;
               end else begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               // a is odd here; b is reduced until it reaches zero.
               if (b_q == '0) begin
                  res_q   <= a_q << k_q;
                  state_q <= S_PUSH;
               end else if (!b_q[0]) begin
                  b_q <= b_q >> 1;
               end else if (a_q > b_q) begin
                  a_q <= b_q;
                  b_q <= a_q - b_q;
               end else begin
                  b_q <= b_q - a_q;
               end
            end
            S_PUSH: begin
               if (!fifo_full) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO pointer and occupancy next-state.
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO pointer and occupancy registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage write.
   // NOTE: storage is not reset; stale contents are never visible because the
   // head outputs are gated by output_valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_gcd_q[wr_ptr_q] <= res_q;
         mem_tag_q[wr_ptr_q] <= tag_q;
      end
   end

`ifdef GCD_STATS_EN
   logic [CYC_W-1:0] cyc_q;
   logic [CYC_W-1:0] cyc_inc;
   logic [CYC_W-1:0] mem_cyc_q [DEPTH];

   // Saturating increment; the value written with a result includes the write cycle.
   assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
   assign cycles  = output_valid ? mem_cyc_q[rd_ptr_q] : '0;

   // Job cycle counter: cleared on accept, counts every cycle the engine is busy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
      end else if (accept) begin
         cyc_q <= '0;
      end else if (state_q != S_IDLE) begin
         cyc_q <= cyc_inc;
      end
   end

   // Cycle count stored alongside each result.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_cyc_q[wr_ptr_q] <= cyc_inc;
      end
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gcd_binary_queue.sv
// Testbench for gcd_binary_queue: directed cases with literal expectations plus
// randomized jobs checked against a Euclid-based reference and an in-order queue.
module tb_gcd_binary_queue;

   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;
   localparam int CYC_W = 16;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               clock;
   logic               reset;
   logic               input_ready;
   logic               input_valid;
   logic [WIDTH-1:0]   x;
   logic [WIDTH-1:0]   y;
   logic [TAG_W-1:0]   in_tag;
   logic               output_ready;
   logic               output_valid;
   logic [WIDTH-1:0]   gcd;
   logic [TAG_W-1:0]   out_tag;
   logic               busy;
   logic [CNT_W-1:0]   count;
`ifdef GCD_STATS_EN
   logic [CYC_W-1:0]   cycles;
`endif

   gcd_binary_queue #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .DEPTH (DEPTH),
      .CYC_W (CYC_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .input_ready  (input_ready),
      .input_valid  (input_valid),
      .x            (x),
      .y            (y),
      .in_tag       (in_tag),
      .output_ready (output_ready),
      .output_valid (output_valid),
      .gcd          (gcd),
      .out_tag      (out_tag),
      .busy         (busy),
      .count        (count)
`ifdef GCD_STATS_EN
      ,
      .cycles       (cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [WIDTH-1:0] g;
      logic [TAG_W-1:0] t;
      int               cyc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   rand_rdy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Reference GCD by Euclid's remainder method.
   function automatic logic [WIDTH-1:0] model_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      p = a;
      q = b;
      while (q != '0) begin
         r = p % q;
         p = q;
         q = r;
      end
      return p;
   endfunction

   // Advance to just after the next rising edge; optionally randomize output_ready.
   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_rdy) output_ready = 1'($urandom_range(0, 1));
   endtask

   // Compare one cycle: whenever a pop will happen, the head must match the model.
   task automatic compare_step();
      exp_t e;
      @(negedge clock);
      if (!reset && output_valid && output_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got gcd=%0h tag=%0h required no result", gcd, out_tag);
         end else begin
            e = exp_q.pop_front();
            check("gcd", 64'(gcd), 64'(e.g));
            check("out_tag", 64'(out_tag), 64'(e.t));
`ifdef GCD_STATS_EN
            if (e.cyc >= 0) check("cycles", 64'(cycles), 64'(e.cyc));
`endif
         end
      end
   endtask

   task automatic submit(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] ya,
                         input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] eg, input int ec);
      exp_t e;
      int   n;
      n = 0;
      while (!input_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!input_ready) begin
         total++;
         bad++;
         $display("FAIL submit_timeout: input_ready=%0b required 1", input_ready);
      end else begin
         x           = xa;
         y           = ya;
         in_tag      = t;
         input_valid = 1'b1;
         e.g   = eg;
         e.t   = t;
         e.cyc = ec;
         exp_q.push_back(e);
         tick();
         input_valid = 1'b0;
      end
   endtask

   task automatic drain(input string name);
      int n;
      output_ready = 1'b1;
      n = 0;
      while (!(count == '0 && !busy && exp_q.size() == 0) && n < 3000) begin
         tick();
         n++;
      end
      check({name, "_count"}, 64'(count), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_input_ready"}, 64'(input_ready), 64'd1);
      check({name, "_output_valid"}, 64'(output_valid), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_count"}, 64'(count), 64'd0);
      check({name, "_gcd"}, 64'(gcd), 64'd0);
      check({name, "_out_tag"}, 64'(out_tag), 64'd0);
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int               lat;
      int               sh;

      fork
         forever compare_step();
      join_none

      reset        = 1'b1;
      input_valid  = 1'b0;
      output_ready = 1'b0;
      x            = '0;
      y            = '0;
      in_tag       = '0;
      #12;
      check_reset_values("reset");
      @(negedge clock);
      reset = 1'b0;
      tick();

      // Reference model pinned to hand-computed values.
      check("model_48_18", 64'(model_gcd(48, 18)), 64'd6);
      check("model_1071_462", 64'(model_gcd(1071, 462)), 64'd21);
      check("model_0_9", 64'(model_gcd(0, 9)), 64'd9);

      // Basic job.
      output_ready = 1'b1;
      submit(48, 18, 3, 6, -1);
      drain("basic");

      // Zero operands leave STRIP on the first cycle.
      submit(0, 7, 1, 7, 2);
      submit(7, 0, 2, 7, 2);
      submit(0, 0, 5, 0, 2);
      drain("zeros");

      // Deep common power of two.
      submit(32'h8000_0000, 32'h4000_0000, 6, 32'h4000_0000, -1);
      drain("pow2");

      // Worst-case style operands with latency bound.
      output_ready = 1'b0;
      submit(32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, 1, -1);
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (output_valid) begin
            lat = i;
            break;
         end
      end
      check("latency_written", 64'(lat != 0), 64'd1);
      check("latency_bound", 64'(lat <= 6 * WIDTH + 4), 64'd1);
      drain("latency");

      // Fill the FIFO and stall the fifth job in PUSH.
      output_ready = 1'b0;
      submit(12, 8, 0, 4, -1);
      submit(9, 6, 1, 3, -1);
      submit(35, 14, 2, 7, -1);
      submit(17, 5, 3, 1, -1);
      submit(100, 75, 4, 25, -1);
      for (int i = 0; i < 250; i++) tick();
      check("full_count", 64'(count), 64'd4);
      check("full_busy", 64'(busy), 64'd1);
      check("full_input_ready", 64'(input_ready), 64'd0);

      // Pop while full with a pending push: pop wins now, push lands next cycle.
      output_ready = 1'b1;
      tick();
      output_ready = 1'b0;
      check("popfull_count", 64'(count), 64'd3);
      check("popfull_busy", 64'(busy), 64'd1);
      tick();
      check("pushlate_count", 64'(count), 64'd4);
      check("pushlate_busy", 64'(busy), 64'd0);
      drain("full");

      // Asynchronous reset mid-job with a result already queued.
      output_ready = 1'b0;
      submit(10, 4, 8, 2, -1);
      for (int i = 0; i < 60; i++) tick();
      check("prereset_count", 64'(count), 64'd1);
      submit(1071, 462, 9, 21, -1);
      for (int i = 0; i < 5; i++) tick();
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      exp_q.delete();
      #3;
      reset = 1'b0;
      tick();
      check("no_stale_valid", 64'(output_valid), 64'd0);
      output_ready = 1'b1;
      submit(1071, 462, 9, 21, -1);
      drain("resubmit");

      // Randomized jobs with random consumer backpressure.
      rand_rdy = 1'b1;
      for (int j = 0; j < 150; j++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: begin
               ra = ra % 1000;
               rb = rb % 1000;
            end
            1: begin
               sh = $urandom_range(0, 12);
               ra = (ra % 4096) << sh;
               rb = (rb % 4096) << sh;
            end
            2: begin
               if ($urandom_range(0, 1) == 1) ra = '0;
               else rb = '0;
            end
            default: ;
         endcase
         submit(ra, rb, TAG_W'(j), model_gcd(ra, rb), -1);
      end
      rand_rdy = 1'b0;
      drain("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
